// File: rtl/door_plant_model.sv
// Behavioural-but-synthesizable door mechanism: integrates motor drive into a position and reports limit switches.
// Optional overrun monitor (overrun_cnt / overrun ports) is built only when DOOR_OVERRUN_EN is defined.
module door_plant_model #(
  parameter int TRAVEL   = 16,
  parameter int STEP_DIV = 4,
  parameter int POS_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_motor,
  input  logic             DN_motor,
  output logic             UP_MAX,
  output logic             DN_MAX,
  output logic [POS_W-1:0] position,
  output logic             moving,
  output logic             fault
`ifdef DOOR_OVERRUN_EN
  ,
  output logic [7:0]       overrun_cnt,
  output logic             overrun
`endif
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_TOP    = POS_W'(TRAVEL);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_base, presc_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             last_up, last_up_nxt;
  logic             drive_up, drive_dn, dir_change, step;

  // A legal drive is exactly one motor input, away from that direction's limit, outside FAULT.
  assign drive_up   = UP_motor & ~DN_motor & (state != FAULT) & (position < POS_TOP);
  assign drive_dn   = DN_motor & ~UP_motor & (state != FAULT) & (position != '0);
  assign dir_change = (drive_up & ~last_up) | (drive_dn & last_up);
  assign presc_base = dir_change ? '0 : presc;
  assign step       = (drive_up | drive_dn) & (presc_base == PRESC_LAST);

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    pos_nxt     = position;
    presc_nxt   = '0;
    last_up_nxt = last_up;
    state_nxt   = state;

    if (drive_up || drive_dn) begin
      last_up_nxt = drive_up;
      if (step) pos_nxt = drive_up ? position + 1'b1 : position - 1'b1;
      else      presc_nxt = presc_base + 1'b1;
    end

    if (UP_motor && DN_motor) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        FAULT: begin
          if (!UP_motor && !DN_motor) begin
            if (position == '0)          state_nxt = CLOSED;
            else if (position == POS_TOP) state_nxt = OPEN;
            else                          state_nxt = CLOSING;
          end
        end
        CLOSED, OPENING, OPEN, CLOSING: begin
          if (drive_up)      state_nxt = (pos_nxt == POS_TOP) ? OPEN : OPENING;
          else if (drive_dn) state_nxt = (pos_nxt == '0) ? CLOSED : CLOSING;
        end
        default: state_nxt = FAULT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= CLOSED;
      position <= '0;
      presc    <= '0;
      last_up  <= 1'b0;
    end else begin
      state    <= state_nxt;
      position <= pos_nxt;
      presc    <= presc_nxt;
      last_up  <= last_up_nxt;
    end
  end

  assign UP_MAX = (position == POS_TOP);
  assign DN_MAX = (position == '0);
  assign moving = ((state == OPENING) & UP_motor) | ((state == CLOSING) & DN_motor);
  assign fault  = UP_motor & DN_motor;

`ifdef DOOR_OVERRUN_EN
  logic over_hit, over_prev;

  assign over_hit = (UP_motor & UP_MAX) | (DN_motor & DN_MAX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overrun_cnt <= '0;
      overrun     <= 1'b0;
      over_prev   <= 1'b0;
    end else begin
      over_prev <= over_hit;
      overrun   <= over_hit & ~over_prev;
      if (over_hit && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_door_plant_model.sv
// Directed bench for door_plant_model: expected values are queued per step and checked against DUT outputs.
module tb_door_plant_model;

  logic       CLK = 1'b0;
  logic       RST;
  logic       UP_motor, DN_motor;
  logic       UP_MAX, DN_MAX, moving, fault;
  logic [7:0] position;
`ifdef DOOR_OVERRUN_EN
  logic [7:0] overrun_cnt;
  logic       overrun;
`endif

  door_plant_model #(.TRAVEL(16), .STEP_DIV(4), .POS_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .UP_motor (UP_motor),
    .DN_motor (DN_motor),
    .UP_MAX   (UP_MAX),
    .DN_MAX   (DN_MAX),
    .position (position),
    .moving   (moving),
    .fault    (fault)
`ifdef DOOR_OVERRUN_EN
    ,
    .overrun_cnt (overrun_cnt),
    .overrun     (overrun)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.exp && tag == e.tag) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d (queued as %s)", tag, obs, e.exp, e.tag);
      end
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic up, input logic dn);
    UP_motor = up;
    DN_motor = dn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    drive(0, 0);
    cycles(2);
    RST = 1'b1;

    // Idle after reset
    sb_push("rst_pos", 0); sb_push("rst_dnmax", 1); sb_push("rst_upmax", 0);
    sb_push("rst_fault", 0); sb_push("rst_moving", 0);
    cycles(10);
    check("rst_pos", position); check("rst_dnmax", DN_MAX); check("rst_upmax", UP_MAX);
    check("rst_fault", fault); check("rst_moving", moving);

    // Full opening travel: 16 steps of 4 cycles each
    drive(1, 0);
    sb_push("open_moving", 1); sb_push("open_pos_e3", 0);
    cycles(3);
    check("open_moving", moving); check("open_pos_e3", position);
    sb_push("open_pos_e4", 1);
    cycles(1);
    check("open_pos_e4", position);
    sb_push("open_pos_e63", 15); sb_push("open_upmax_e63", 0);
    cycles(59);
    check("open_pos_e63", position); check("open_upmax_e63", UP_MAX);
    sb_push("open_pos_e64", 16); sb_push("open_upmax_e64", 1);
    sb_push("open_moving_e64", 0); sb_push("open_dnmax_e64", 0);
    cycles(1);
    check("open_pos_e64", position); check("open_upmax_e64", UP_MAX);
    check("open_moving_e64", moving); check("open_dnmax_e64", DN_MAX);

    // Driving into the upper limit holds position
    sb_push("sat_pos", 16); sb_push("sat_upmax", 1); sb_push("sat_moving", 0);
    cycles(10);
    check("sat_pos", position); check("sat_upmax", UP_MAX); check("sat_moving", moving);

    // Close for 20 cycles, then reverse
    drive(0, 1);
    sb_push("dn20_pos", 11); sb_push("dn20_moving", 1);
    cycles(20);
    check("dn20_pos", position); check("dn20_moving", moving);
    drive(1, 0);
    sb_push("rev_pos_e3", 11);
    cycles(3);
    check("rev_pos_e3", position);
    sb_push("rev_pos_e4", 12);
    cycles(1);
    check("rev_pos_e4", position);
    sb_push("rev_pos_e20", 16); sb_push("rev_upmax_e20", 1);
    cycles(16);
    check("rev_pos_e20", position); check("rev_upmax_e20", UP_MAX);

    // Close to position 5, then assert both motors
    drive(0, 1);
    sb_push("mid_pos", 5);
    cycles(44);
    check("mid_pos", position);
    drive(1, 1);
    sb_push("flt_fault_1", 1); sb_push("flt_pos_1", 5);
    cycles(1);
    check("flt_fault_1", fault); check("flt_pos_1", position);
    sb_push("flt_fault_3", 1); sb_push("flt_pos_3", 5); sb_push("flt_moving_3", 0);
    cycles(2);
    check("flt_fault_3", fault); check("flt_pos_3", position); check("flt_moving_3", moving);

    // One input still high keeps the door parked in FAULT
    drive(1, 0);
    sb_push("flt_one_pos", 5); sb_push("flt_one_moving", 0); sb_push("flt_one_fault", 0);
    cycles(3);
    check("flt_one_pos", position); check("flt_one_moving", moving); check("flt_one_fault", fault);

    // Both low re-arms into CLOSING (visible as moving as soon as DN is applied)
    drive(0, 0);
    cycles(1);
    drive(0, 1);
    sb_push("rearm_moving", 1);
    #1;
    check("rearm_moving", moving);
    sb_push("rearm_pos_e3", 5);
    cycles(3);
    check("rearm_pos_e3", position);
    sb_push("rearm_pos_e4", 4);
    cycles(1);
    check("rearm_pos_e4", position);
    sb_push("closed_pos", 0); sb_push("closed_dnmax", 1); sb_push("closed_moving", 0);
    cycles(16);
    check("closed_pos", position); check("closed_dnmax", DN_MAX); check("closed_moving", moving);

    // Reversal with a partly-filled prescaler restarts the count
    drive(1, 0);
    sb_push("pre_pos", 1);
    cycles(6);
    check("pre_pos", position);
    drive(0, 1);
    sb_push("pre_rev_e3", 1);
    cycles(3);
    check("pre_rev_e3", position);
    sb_push("pre_rev_e4", 0); sb_push("pre_rev_dnmax", 1);
    cycles(1);
    check("pre_rev_e4", position); check("pre_rev_dnmax", DN_MAX);

    // Asynchronous reset mid-opening at position 9
    drive(1, 0);
    sb_push("arst_pre_pos", 9);
    cycles(36);
    check("arst_pre_pos", position);
    #2;
    RST = 1'b0;
    sb_push("arst_pos", 0); sb_push("arst_dnmax", 1); sb_push("arst_upmax", 0); sb_push("arst_moving", 0);
    #1;
    check("arst_pos", position); check("arst_dnmax", DN_MAX);
    check("arst_upmax", UP_MAX); check("arst_moving", moving);
    drive(0, 0);
    #1;
    RST = 1'b1;
    sb_push("post_rst_pos", 0);
    cycles(2);
    check("post_rst_pos", position);

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
